// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR coefficient loader
//
// Purpose: tap count, coefficient width, counter widths, coefficient type and
// the loader state encoding, shared by the loader RTL and its bench.
package fir_pkg;

  localparam int NUM_TAPS = 41;
  localparam int COEFF_W  = 16;
  // Tap index width.
  localparam int IDX_W    = $clog2(NUM_TAPS);
  // Shared index/settle counter must also hold the value NUM_TAPS.
  localparam int CNT_W    = $clog2(NUM_TAPS + 1);

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - sequences coefficient loads, commits and delay-line settle for the 41-tap FIR
//
// Purpose: collects NUM_TAPS coefficients into a shadow bank, commits the bank
// to the filter with a one-cycle strobe, then stalls/invalidates the sample
// path until the filter delay line holds only data filtered by the new taps.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_start           begins (or restarts) a coefficient load
//   cfg_valid/cfg_data/cfg_last/cfg_ready   coefficient beat stream, tap 0 first
//   cfg_busy            high while loading, committing or settling
//   cfg_done            one-cycle pulse when a commit has settled
//   cfg_error           one-cycle pulse when a set is aborted on a framing error
//   coeff_out           shadow bank, tap i at [i*COEFF_W +: COEFF_W]
//   update_coeff        one-cycle commit strobe to the filter
//   samp_in_valid/samp_in_data/samp_in_ready   upstream sample stream
//   fir_data_in         sample presented to the filter (zero when stalled)
//   out_valid           qualifies the filter output
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  input  coeff_t                        cfg_data,
  input  logic                          cfg_last,
  output logic                          cfg_ready,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_error,
  output logic [NUM_TAPS*COEFF_W-1:0]   coeff_out,
  output logic                          update_coeff,
  input  logic                          samp_in_valid,
  input  coeff_t                        samp_in_data,
  output logic                          samp_in_ready,
  output coeff_t                        fir_data_in,
  output logic                          out_valid
);

  ldr_state_e                 state_q, state_d;
  // Tap index while in LOAD, settle countdown while in SETTLE.
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  coeff_t [NUM_TAPS-1:0]      coeff_q, coeff_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic                       coeff_valid_q, coeff_valid_d;
  logic                       samp_rdy_q, samp_rdy_d;
  logic                       at_last_idx;

  assign at_last_idx = (cnt_q == CNT_W'(NUM_TAPS - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    coeff_d       = coeff_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    coeff_valid_d = coeff_valid_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        // A restart wins over a coincident beat, which is dropped.
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          // Aborted beats still land in the shadow; no commit follows them.
          coeff_d[cnt_q[IDX_W-1:0]] = cfg_data;
          if (at_last_idx) begin
            if (cfg_last) begin
              state_d = COMMIT;
            end else begin
              state_d = IDLE;
              error_d = 1'b1;
            end
          end else if (cfg_last) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      COMMIT: begin
        state_d = SETTLE;
        cnt_d   = CNT_W'(NUM_TAPS);
      end

      SETTLE: begin
        // NUM_TAPS+1 cycles: count NUM_TAPS down to and including 0.
        if (cnt_q == '0) begin
          state_d       = IDLE;
          done_d        = 1'b1;
          coeff_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so both track the state register exactly and reset to 0.
    busy_d     = (state_d != IDLE);
    samp_rdy_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      coeff_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      coeff_valid_q <= 1'b0;
      samp_rdy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      coeff_q       <= coeff_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      coeff_valid_q <= coeff_valid_d;
      samp_rdy_q    <= samp_rdy_d;
    end
  end

  assign cfg_ready    = (state_q == LOAD);
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_error    = error_q;
  assign coeff_out    = coeff_q;
  assign update_coeff = (state_q == COMMIT);
  assign samp_in_ready = samp_rdy_q;
  // Zeros are flushed into the filter delay line whenever no sample transfers.
  assign fir_data_in  = (samp_in_valid && samp_rdy_q) ? samp_in_data : '0;
  assign out_valid    = coeff_valid_q && ((state_q == IDLE) || (state_q == LOAD));

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - scoreboard bench for fir_coeff_loader
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int EV_COMMIT = 0;
  localparam int EV_ERROR  = 1;
  localparam int EV_DONE   = 2;
  localparam int BANK_W    = NUM_TAPS * COEFF_W;

  typedef struct {
    int                kind;
    logic [BANK_W-1:0] bank;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_start, cfg_valid, cfg_last;
  logic [15:0]       cfg_data;
  logic              cfg_ready, cfg_busy, cfg_done, cfg_error;
  logic [BANK_W-1:0] coeff_out;
  logic              update_coeff;
  logic              samp_in_valid;
  logic [15:0]       samp_in_data;
  logic              samp_in_ready;
  logic [15:0]       fir_data_in;
  logic              out_valid;

  fir_coeff_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .cfg_ready    (cfg_ready),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .coeff_out    (coeff_out),
    .update_coeff (update_coeff),
    .samp_in_valid(samp_in_valid),
    .samp_in_data (samp_in_data),
    .samp_in_ready(samp_in_ready),
    .fir_data_in  (fir_data_in),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  ev_t         sb[$];
  logic [15:0] model [NUM_TAPS];
  bit          armed   = 1'b0;
  bit          in_cs   = 1'b0;
  bit          exp_cv  = 1'b0;
  int          cyc     = 0;
  int          commit_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bank(input string name, input logic [BANK_W-1:0] act, input logic [BANK_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (act[i*COEFF_W +: COEFF_W] !== exp[i*COEFF_W +: COEFF_W]) begin
          $display("FAIL %s: tap %0d got %0h expected %0h", name, i,
                   act[i*COEFF_W +: COEFF_W], exp[i*COEFF_W +: COEFF_W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BANK_W-1:0] pack_model();
    logic [BANK_W-1:0] b;
    for (int i = 0; i < NUM_TAPS; i++) b[i*COEFF_W +: COEFF_W] = model[i];
    return b;
  endfunction

  task automatic pop_ev(input int kind, input string nm);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: event seen, expected no event", nm);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        n_fail++;
        $display("FAIL %s: got event kind %0d expected kind %0d", nm, kind, e.kind);
      end else if (kind == EV_COMMIT) begin
        chk_bank("commit_bank", coeff_out, e.bank);
      end
    end
  endtask

  // Monitor: pops the scoreboard on DUT events and checks the sample path.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && armed) begin
        if (update_coeff) begin
          pop_ev(EV_COMMIT, "update_coeff");
          commit_cyc = cyc;
          in_cs = 1'b1;
        end
        if (cfg_error) pop_ev(EV_ERROR, "cfg_error");
        if (cfg_done) begin
          pop_ev(EV_DONE, "cfg_done");
          chk("done_latency", 64'(cyc - commit_cyc), 64'd43);
          in_cs  = 1'b0;
          exp_cv = 1'b1;
        end
        chk("samp_in_ready", samp_in_ready, !update_coeff);
        chk("fir_data_in", fir_data_in, (samp_in_valid && !update_coeff) ? samp_in_data : 16'h0);
        chk("out_valid", out_valid, exp_cv && !in_cs);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      armed = reset_n;
    end
  end

  initial begin
    samp_in_valid = 1'b0;
    samp_in_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      samp_in_valid = 1'($urandom_range(0, 1));
      samp_in_data  = 16'($urandom);
    end
  end

  task automatic start_load();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Pushes the expected outcome, then drives n beats base+i; last_at<0 means no last.
  task automatic load_set(input int base, input int n, input int last_at,
                          input bit do_start, input bit stall, input bit want_done);
    ev_t e;
    for (int i = 0; i < n; i++) model[i] = 16'(base + i);
    e.bank = pack_model();
    e.kind = (n == NUM_TAPS && last_at == NUM_TAPS - 1) ? EV_COMMIT : EV_ERROR;
    sb.push_back(e);
    if (e.kind == EV_COMMIT && want_done) begin
      e.kind = EV_DONE;
      sb.push_back(e);
    end
    if (do_start) start_load();
    for (int i = 0; i < n; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      beat(16'(base + i), i == last_at);
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events still pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_cfg_busy"}, cfg_busy, 0);
    chk({tag, "_cfg_done"}, cfg_done, 0);
    chk({tag, "_cfg_error"}, cfg_error, 0);
    chk({tag, "_update_coeff"}, update_coeff, 0);
    chk({tag, "_samp_in_ready"}, samp_in_ready, 0);
    chk({tag, "_fir_data_in"}, fir_data_in, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk_bank({tag, "_coeff_out"}, coeff_out, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
    for (int i = 0; i < NUM_TAPS; i++) model[i] = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);

    // Full load 1..41, last on beat 41.
    load_set(1, NUM_TAPS, NUM_TAPS - 1, 1, 0, 1);
    wait_drain("full_load", 100);
    chk("tap0", coeff_out[0 +: COEFF_W], 16'd1);
    chk("tap40", coeff_out[40*COEFF_W +: COEFF_W], 16'd41);
    chk("after_commit_busy", cfg_busy, 0);

    // Early last on beat 10.
    load_set(101, 10, 9, 1, 0, 0);
    wait_drain("early_last", 10);
    chk("early_last_busy", cfg_busy, 0);
    chk("early_last_out_valid", out_valid, 1);
    chk_bank("early_last_shadow", coeff_out, pack_model());

    // Missing last, then a normal load.
    load_set(201, NUM_TAPS, -1, 1, 0, 0);
    wait_drain("missing_last", 10);
    chk("missing_last_busy", cfg_busy, 0);
    load_set(301, NUM_TAPS, NUM_TAPS - 1, 1, 0, 1);
    wait_drain("after_missing", 100);

    // Upstream stall on cfg_valid.
    load_set(401, NUM_TAPS, NUM_TAPS - 1, 1, 1, 1);
    wait_drain("stall_load", 100);

    // Restart at idx 20 with a coincident beat that must be dropped.
    start_load();
    for (int i = 0; i < 20; i++) begin
      model[i] = 16'(501 + i);
      beat(16'(501 + i), 1'b0);
    end
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hDEAD;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    load_set(601, NUM_TAPS, NUM_TAPS - 1, 0, 0, 1);
    wait_drain("restart", 100);
    chk_bank("restart_shadow", coeff_out, pack_model());

    // Asynchronous reset in SETTLE.
    load_set(701, NUM_TAPS, NUM_TAPS - 1, 1, 0, 0);
    wait_drain("settle_commit", 10);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    in_cs  = 1'b0;
    exp_cv = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) model[i] = '0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    load_set(1, NUM_TAPS, NUM_TAPS - 1, 1, 0, 1);
    wait_drain("post_reset_load", 100);
    chk("final_out_valid", out_valid, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
